demux1_2_stream: RTL and testbench
==================================

// Module: demux1_2_stream
// PURPOSE
//   1-to-2 streaming demultiplexer, the inverse of the 2:1 operand mux.
//   Steers each accepted n-bit word from one producer (e.g. an RK stage
//   result) to one of two consumers (e.g. k-accumulator or next-stage
//   operand path), selected per word by SEL.
//   Each output has its own 2-entry FIFO, so a stalled consumer only
//   blocks words addressed to it. Full throughput is 1 word/cycle.
// PARAMETERS
//   n   32  data word width in bits
//   CW  16  width of per-output transfer counters
// PORTS
//   CLK          in   1    single clock; all state updates on rising edge
//   RST_N        in   1    synchronous reset, active-low
//   IN_DATA      in   n    input word
//   SEL          in   1    destination: 0 -> OUT_0, 1 -> OUT_1
//   IN_VALID     in   1    producer has a word on IN_DATA/SEL
//   IN_READY     out  1    block accepts the word this cycle
//   OUT_0        out  n    head word of FIFO 0
//   OUT_0_VALID  out  1    FIFO 0 not empty
//   OUT_0_READY  in   1    consumer 0 takes the head word
//   OUT_1        out  n    head word of FIFO 1
//   OUT_1_VALID  out  1    FIFO 1 not empty
//   OUT_1_READY  in   1    consumer 1 takes the head word
//   CNT_0        out  CW   words delivered on OUT_0 (wraps)
//   CNT_1        out  CW   words delivered on OUT_1 (wraps)
// BEHAVIOUR
//   Reset (RST_N=0 at a rising edge):
//   - both FIFOs are emptied and both CNT_x are cleared.
//   - OUT_x_VALID=0, OUT_x=0, CNT_x=0 from the next cycle.
//   - IN_READY is forced to 0 combinationally while RST_N=0.
//   - Reset mid-transfer discards buffered words; nothing is delivered.
//   Input handshake:
//   - IN_READY = RST_N & ~full[SEL], combinational in SEL.
//   - Accept occurs when IN_VALID & IN_READY at a rising edge.
//   - Once IN_VALID is high, the producer holds IN_DATA and SEL stable
//     until the accept.
//   - An accepted word is pushed into FIFO[SEL].
//   Output handshake:
//   - OUT_x_VALID = ~empty[x]; OUT_x = head of FIFO x.
//   - Pop occurs when OUT_x_VALID & OUT_x_READY at a rising edge.
//   - Latency: an accepted word is visible on OUT_x the next cycle if
//     FIFO x was empty.
//   FIFO (per output): depth 2, count 0..2, registered rd/wr pointers.
//   - Push and pop in the same cycle at count=1: count stays 1; the new
//     word becomes head next cycle.
//   - Push at count=2 cannot occur because IN_READY=0.
//   - Pop at count=0 cannot occur because VALID=0.
//   - OUT_x holds the last head value when empty; consumers must ignore
//     it (OUT_x=0 only after reset).
//   Ordering and counters:
//   - Order is preserved within each output. No ordering is implied
//     across outputs.
//   - CNT_x increments by 1 on every pop of FIFO x and wraps
//     2^CW-1 -> 0.
//   - Both outputs may pop in the same cycle as an input push; all
//     three events are independent.
// TESTING
//   1. Reset: drive RST_N=0 with IN_VALID=1 -> IN_READY=0; after
//      release: OUT_x_VALID=0, CNT_x=0, IN_READY=1.
//   2. Single word 0xDEADBEEF, SEL=1, OUT_1_READY=1 -> OUT_1=0xDEADBEEF
//      valid 1 cycle later; OUT_0_VALID stays 0; CNT_1=1.
//   3. OUT_0_READY=0, push 3 words with SEL=0 -> first two accepted,
//      IN_READY=0 on the third. Switching SEL=1 shows IN_READY=1 but is
//      illegal while IN_VALID=1; check via assertion.
//   4. Both READY=1, alternate SEL on 100 back-to-back words -> 1
//      word/cycle accepted; per-port order matches the scoreboard;
//      CNT_0=CNT_1=50.
//   5. At FIFO 0 count=1, push and pop in the same cycle -> count stays
//      1; the next head is the new word.
//   6. CW=4: deliver 17 words on OUT_0 -> CNT_0 wraps to 1. Then assert
//      RST_N with 2 words buffered -> both dropped, CNT_0=0.

Source files
------------

// File: rtl/demux1_2_stream_if.sv
// Stream bundle for the 1:2 demultiplexer: one producer-side input, two consumer-side outputs.
// The master side is the producer together with both consumers; the slave side is the demux.
interface demux1_2_stream_if #(
  parameter int n = 32
);
  logic [n-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [n-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
endinterface

// File: rtl/demux1_2_stream.sv
// 1:2 streaming demux: each accepted word is pushed into FIFO[sel], where each FIFO is 2 deep
// and has its own valid/ready output, so a stalled consumer only blocks its own traffic.
module demux1_2_stream #(
  parameter int n  = 32,
  parameter int CW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  demux1_2_stream_if.slave bus,
  output logic [CW-1:0]   cnt_0_o,
  output logic [CW-1:0]   cnt_1_o
);

  logic [1:0] full_w;
  logic [1:0] out_ready_w;
  logic       in_ready_w;
  logic       accept_w;

  assign out_ready_w = {bus.out1_ready, bus.out0_ready};
  assign in_ready_w  = rst_ni & ~full_w[bus.in_sel];
  assign accept_w    = bus.in_valid & in_ready_w;

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [n-1:0]  mem_q [2];
    logic [n-1:0]  mem_d [2];
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [1:0]    count_q, count_d;
    logic [n-1:0]  head_q, head_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;
    logic          pop;

    assign push = accept_w & (bus.in_sel == 1'(g));
    assign pop  = (count_q != 2'd0) & out_ready_w[g];

    // head_q is a registered copy of the next head so the output holds its last value when empty
    always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      cnt_d   = cnt_q;
      if (push) begin
        mem_d[wr_q] = bus.in_data;
        wr_d        = ~wr_q;
      end
      if (pop) begin
        rd_d  = ~rd_q;
        cnt_d = cnt_q + CW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      head_d = (count_d != 2'd0) ? mem_d[rd_d] : head_q;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        wr_q    <= 1'b0;
        rd_q    <= 1'b0;
        count_q <= 2'd0;
        cnt_q   <= '0;
        head_q  <= '0;
      end else begin
        wr_q    <= wr_d;
        rd_q    <= rd_d;
        count_q <= count_d;
        cnt_q   <= cnt_d;
        head_q  <= head_d;
      end
    end

    // Storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
    end
  end

  assign full_w = {g_fifo[1].count_q == 2'd2, g_fifo[0].count_q == 2'd2};

  assign bus.in_ready   = in_ready_w;
  assign bus.out0_data  = g_fifo[0].head_q;
  assign bus.out0_valid = g_fifo[0].count_q != 2'd0;
  assign bus.out1_data  = g_fifo[1].head_q;
  assign bus.out1_valid = g_fifo[1].count_q != 2'd0;
  assign cnt_0_o        = g_fifo[0].cnt_q;
  assign cnt_1_o        = g_fifo[1].cnt_q;

endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed bench for demux1_2_stream: a CW=16 instance for the main scenarios and a CW=4
// instance for counter wrap and reset-with-buffered-data.
module tb_demux1_2_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b;
  logic [15:0] cnt0_a, cnt1_a;
  logic [3:0]  cnt0_b, cnt1_b;

  demux1_2_stream_if #(.n(32)) ifa ();
  demux1_2_stream_if #(.n(32)) ifb ();

  demux1_2_stream #(.n(32), .CW(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n_a), .bus(ifa), .cnt_0_o(cnt0_a), .cnt_1_o(cnt1_a));
  demux1_2_stream #(.n(32), .CW(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n_b), .bus(ifb), .cnt_0_o(cnt0_b), .cnt_1_o(cnt1_b));

  int checks = 0;
  int failures = 0;

  // Producer must hold sel/data while stalled with valid high.
  a_hold: assert property (@(posedge clk) disable iff (!rst_n_a)
    (ifa.in_valid && !ifa.in_ready) |=> (!ifa.in_valid || ($stable(ifa.in_sel) && $stable(ifa.in_data))))
    else $error("FAIL sel_hold got=changed exp=stable");

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_sel = 1'b0; ifa.in_data = 32'h0;
    ifa.out0_ready = 1'b0; ifa.out1_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_sel = 1'b0; ifb.in_data = 32'h0;
    ifb.out0_ready = 1'b0; ifb.out1_ready = 1'b0;
    cyc(); cyc();
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", ifa.in_ready); end
    checks++; if (ifa.out0_valid !== 1'b0) begin failures++; $display("FAIL rst_out0_valid got=%b exp=0", ifa.out0_valid); end
    checks++; if (ifa.out1_valid !== 1'b0) begin failures++; $display("FAIL rst_out1_valid got=%b exp=0", ifa.out1_valid); end
    checks++; if (cnt0_a !== 16'd0) begin failures++; $display("FAIL rst_cnt0 got=%0d exp=0", cnt0_a); end
    checks++; if (cnt1_a !== 16'd0) begin failures++; $display("FAIL rst_cnt1 got=%0d exp=0", cnt1_a); end
    checks++; if (ifa.out0_data !== 32'h0) begin failures++; $display("FAIL rst_out0_data got=%h exp=0", ifa.out0_data); end
    ifa.in_valid = 1'b0;
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%b exp=1", ifa.in_ready); end
  endtask

  task automatic test_single();
    ifa.in_sel = 1'b1; ifa.in_data = 32'hDEADBEEF; ifa.in_valid = 1'b1; ifa.out1_ready = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", ifa.in_ready); end
    cyc();
    ifa.in_valid = 1'b0;
    checks++; if (ifa.out1_valid !== 1'b1) begin failures++; $display("FAIL single_out1_valid got=%b exp=1", ifa.out1_valid); end
    checks++; if (ifa.out1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_out1_data got=%h exp=deadbeef", ifa.out1_data); end
    checks++; if (ifa.out0_valid !== 1'b0) begin failures++; $display("FAIL single_out0_valid got=%b exp=0", ifa.out0_valid); end
    checks++; if (cnt1_a !== 16'd0) begin failures++; $display("FAIL single_cnt1_pre got=%0d exp=0", cnt1_a); end
    cyc();
    checks++; if (ifa.out1_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b exp=0", ifa.out1_valid); end
    checks++; if (cnt1_a !== 16'd1) begin failures++; $display("FAIL single_cnt1 got=%0d exp=1", cnt1_a); end
    checks++; if (cnt0_a !== 16'd0) begin failures++; $display("FAIL single_cnt0 got=%0d exp=0", cnt0_a); end
    ifa.out1_ready = 1'b0;
  endtask

  task automatic test_fill();
    ifa.out0_ready = 1'b0; ifa.out1_ready = 1'b0;
    ifa.in_sel = 1'b0; ifa.in_data = 32'hA0000001; ifa.in_valid = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL fill_rdy1 got=%b exp=1", ifa.in_ready); end
    cyc();
    ifa.in_data = 32'hA0000002;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL fill_rdy2 got=%b exp=1", ifa.in_ready); end
    cyc();
    ifa.in_data = 32'hA0000003;
    #1;
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL fill_rdy3 got=%b exp=0", ifa.in_ready); end
    checks++; if (ifa.out0_data !== 32'hA0000001) begin failures++; $display("FAIL fill_head got=%h exp=a0000001", ifa.out0_data); end
    cyc();
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL fill_stall got=%b exp=0", ifa.in_ready); end
    ifa.in_valid = 1'b0;
    ifa.in_sel = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL fill_sel1_rdy got=%b exp=1", ifa.in_ready); end
    ifa.in_sel = 1'b0;
    #1;
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL fill_sel0_rdy got=%b exp=0", ifa.in_ready); end
    ifa.out0_ready = 1'b1;
    cyc();
    checks++; if (ifa.out0_data !== 32'hA0000002) begin failures++; $display("FAIL fill_second got=%h exp=a0000002", ifa.out0_data); end
    cyc();
    checks++; if (ifa.out0_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", ifa.out0_valid); end
    checks++; if (cnt0_a !== 16'd2) begin failures++; $display("FAIL fill_cnt0 got=%0d exp=2", cnt0_a); end
    ifa.out0_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] w;
    int got0 = 0;
    int got1 = 0;
    rst_n_a = 1'b0;
    cyc();
    rst_n_a = 1'b1;
    ifa.out0_ready = 1'b1; ifa.out1_ready = 1'b1;
    for (int i = 0; i < 102; i++) begin
      if (ifa.out0_valid === 1'b1) begin
        got0++; checks++;
        if (q0.size() == 0) begin failures++; $display("FAIL b2b_extra0 got=%h exp=none", ifa.out0_data); end
        else begin
          if (ifa.out0_data !== q0[0]) begin failures++; $display("FAIL b2b_data0 got=%h exp=%h", ifa.out0_data, q0[0]); end
          void'(q0.pop_front());
        end
      end
      if (ifa.out1_valid === 1'b1) begin
        got1++; checks++;
        if (q1.size() == 0) begin failures++; $display("FAIL b2b_extra1 got=%h exp=none", ifa.out1_data); end
        else begin
          if (ifa.out1_data !== q1[0]) begin failures++; $display("FAIL b2b_data1 got=%h exp=%h", ifa.out1_data, q1[0]); end
          void'(q1.pop_front());
        end
      end
      if (i < 100) begin
        w = 32'h10000000 + 32'(i);
        ifa.in_sel = i[0]; ifa.in_data = w; ifa.in_valid = 1'b1;
        #1;
        checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy got=%b exp=1 word=%0d", ifa.in_ready, i); end
        if (i[0]) q1.push_back(w); else q0.push_back(w);
      end else begin
        ifa.in_valid = 1'b0;
      end
      cyc();
    end
    checks++; if (got0 != 50) begin failures++; $display("FAIL b2b_got0 got=%0d exp=50", got0); end
    checks++; if (got1 != 50) begin failures++; $display("FAIL b2b_got1 got=%0d exp=50", got1); end
    checks++; if (cnt0_a !== 16'd50) begin failures++; $display("FAIL b2b_cnt0 got=%0d exp=50", cnt0_a); end
    checks++; if (cnt1_a !== 16'd50) begin failures++; $display("FAIL b2b_cnt1 got=%0d exp=50", cnt1_a); end
    ifa.out0_ready = 1'b0; ifa.out1_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    ifa.in_sel = 1'b0; ifa.in_data = 32'hB0000001; ifa.in_valid = 1'b1;
    cyc();
    ifa.in_valid = 1'b0;
    checks++; if (ifa.out0_data !== 32'hB0000001) begin failures++; $display("FAIL pp_head1 got=%h exp=b0000001", ifa.out0_data); end
    ifa.out0_ready = 1'b1; ifa.in_data = 32'hB0000002; ifa.in_valid = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL pp_rdy got=%b exp=1", ifa.in_ready); end
    cyc();
    ifa.in_valid = 1'b0; ifa.out0_ready = 1'b0;
    checks++; if (ifa.out0_valid !== 1'b1) begin failures++; $display("FAIL pp_valid got=%b exp=1", ifa.out0_valid); end
    checks++; if (ifa.out0_data !== 32'hB0000002) begin failures++; $display("FAIL pp_newhead got=%h exp=b0000002", ifa.out0_data); end
    checks++; if (cnt0_a !== 16'd51) begin failures++; $display("FAIL pp_cnt0 got=%0d exp=51", cnt0_a); end
    ifa.in_data = 32'hB0000003; ifa.in_valid = 1'b1;
    #1;
    checks++; if (ifa.in_ready !== 1'b1) begin failures++; $display("FAIL pp_count1 got=%b exp=1", ifa.in_ready); end
    cyc();
    ifa.in_data = 32'hB0000004;
    #1;
    checks++; if (ifa.in_ready !== 1'b0) begin failures++; $display("FAIL pp_count2 got=%b exp=0", ifa.in_ready); end
    ifa.in_valid = 1'b0; ifa.out0_ready = 1'b1;
    cyc();
    checks++; if (ifa.out0_data !== 32'hB0000003) begin failures++; $display("FAIL pp_order got=%h exp=b0000003", ifa.out0_data); end
    cyc();
    checks++; if (ifa.out0_valid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", ifa.out0_valid); end
    checks++; if (cnt0_a !== 16'd53) begin failures++; $display("FAIL pp_cnt0_end got=%0d exp=53", cnt0_a); end
    ifa.out0_ready = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    ifb.out0_ready = 1'b1; ifb.in_sel = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ifb.in_data = 32'hC0000000 + 32'(i); ifb.in_valid = 1'b1;
      #1;
      checks++; if (ifb.in_ready !== 1'b1) begin failures++; $display("FAIL wrap_rdy got=%b exp=1 word=%0d", ifb.in_ready, i); end
      cyc();
    end
    ifb.in_valid = 1'b0;
    checks++; if (cnt0_b !== 4'd0) begin failures++; $display("FAIL wrap_cnt16 got=%0d exp=0", cnt0_b); end
    checks++; if (ifb.out0_data !== 32'hC0000010) begin failures++; $display("FAIL wrap_last got=%h exp=c0000010", ifb.out0_data); end
    cyc();
    checks++; if (cnt0_b !== 4'd1) begin failures++; $display("FAIL wrap_cnt17 got=%0d exp=1", cnt0_b); end
    checks++; if (ifb.out0_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", ifb.out0_valid); end
    checks++; if (cnt1_b !== 4'd0 || ifb.out1_valid !== 1'b0) begin failures++; $display("FAIL wrap_port1 got=%0d/%b exp=0/0", cnt1_b, ifb.out1_valid); end
    ifb.out0_ready = 1'b0;
    ifb.in_data = 32'hD0000001; ifb.in_valid = 1'b1;
    cyc();
    ifb.in_data = 32'hD0000002;
    cyc();
    ifb.in_valid = 1'b0;
    checks++; if (ifb.out0_data !== 32'hD0000001) begin failures++; $display("FAIL rstbuf_head got=%h exp=d0000001", ifb.out0_data); end
    rst_n_b = 1'b0;
    #1;
    checks++; if (ifb.in_ready !== 1'b0) begin failures++; $display("FAIL rstbuf_rdy got=%b exp=0", ifb.in_ready); end
    cyc();
    checks++; if (ifb.out0_valid !== 1'b0) begin failures++; $display("FAIL rstbuf_valid got=%b exp=0", ifb.out0_valid); end
    checks++; if (cnt0_b !== 4'd0) begin failures++; $display("FAIL rstbuf_cnt got=%0d exp=0", cnt0_b); end
    checks++; if (ifb.out0_data !== 32'h0) begin failures++; $display("FAIL rstbuf_data got=%h exp=0", ifb.out0_data); end
    rst_n_b = 1'b1; ifb.out0_ready = 1'b1;
    cyc();
    checks++; if (ifb.out0_valid !== 1'b0 || cnt0_b !== 4'd0) begin failures++; $display("FAIL rstbuf_after got=%b/%0d exp=0/0", ifb.out0_valid, cnt0_b); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_push_pop();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
